// File: rtl/fir_out_requant.sv
// Output requantizer for the FIR accumulator stream: shift/round/saturate to OUT_W,
// with an output register plus one skid entry so s_axis_rq_tready can be registered.
module fir_out_requant #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 16,
   parameter int SHIFT = 15,
   parameter int ROUND = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  s_axis_rq_tdata,
   input  logic             s_axis_rq_tvalid,
   output logic             s_axis_rq_tready,
   output logic [OUT_W-1:0] m_axis_rq_tdata,
   output logic             m_axis_rq_tvalid,
   input  logic             m_axis_rq_tready,
   input  logic             clear_stats,
   output logic             sat_flag,
   output logic [15:0]      sat_count,
   output logic [1:0]       dbg_state_o
);

   // Handshake: a beat moves on an edge where valid && ready are both high; a
   // presented m_axis beat keeps data and valid stable until it is taken.

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_BUSY  = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   localparam logic signed [IN_W:0] RND_C =
      (ROUND != 0) ? ({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
   localparam logic signed [IN_W:0] SAT_MAX_C =
      {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [IN_W:0] SAT_MIN_C =
      {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
   localparam logic [OUT_W-1:0] OUT_MAX_C = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic [OUT_W-1:0] OUT_MIN_C = {1'b1, {(OUT_W-1){1'b0}}};

   state_e             state_q, state_d;
   logic               s_ready_q;
   logic [OUT_W-1:0]   out_data_q, out_data_d;
   logic [OUT_W-1:0]   skid_data_q, skid_data_d;
   logic               sat_flag_q, sat_flag_d;
   logic [15:0]        sat_count_q, sat_count_d;

   logic signed [IN_W:0] ext_w, sum_w, shr_w;
   logic [OUT_W-1:0]     res_w;
   logic                 sat_w;
   logic                 accept_w, xfer_w;

   // One guard bit keeps the rounding add from wrapping at the positive limit.
   assign ext_w = $signed({s_axis_rq_tdata[IN_W-1], s_axis_rq_tdata});
   assign sum_w = ext_w + RND_C;
   assign shr_w = sum_w >>> SHIFT;

   always_comb begin
      res_w = shr_w[OUT_W-1:0];
      sat_w = 1'b0;
      if (shr_w > SAT_MAX_C) begin
         res_w = OUT_MAX_C;
         sat_w = 1'b1;
      end else if (shr_w < SAT_MIN_C) begin
         res_w = OUT_MIN_C;
         sat_w = 1'b1;
      end
   end

   assign accept_w = s_axis_rq_tvalid && s_ready_q;
   assign xfer_w   = (state_q != ST_EMPTY) && m_axis_rq_tready;

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_EMPTY;
         s_ready_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         s_ready_q <= (state_d != ST_FULL);
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept_w) state_d = ST_BUSY;
         ST_BUSY: begin
            if (accept_w && !xfer_w)      state_d = ST_FULL;
            else if (!accept_w && xfer_w) state_d = ST_EMPTY;
         end
         ST_FULL:  if (xfer_w) state_d = ST_BUSY;
         default:  state_d = ST_EMPTY;
      endcase
   end

   // Output logic
   always_comb begin
      m_axis_rq_tvalid = (state_q != ST_EMPTY);
      s_axis_rq_tready = s_ready_q;
      m_axis_rq_tdata  = out_data_q;
      sat_flag         = sat_flag_q;
      sat_count        = sat_count_q;
      dbg_state_o      = state_q;
   end

   // Buffer datapath: the skid slot only fills when a beat arrives while out is stalled.
   always_comb begin
      out_data_d  = out_data_q;
      skid_data_d = skid_data_q;
      case (state_q)
         ST_EMPTY: if (accept_w) out_data_d = res_w;
         ST_BUSY: begin
            if (accept_w && xfer_w)  out_data_d  = res_w;
            if (accept_w && !xfer_w) skid_data_d = res_w;
         end
         ST_FULL:  if (xfer_w) out_data_d = skid_data_q;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         out_data_q  <= '0;
         skid_data_q <= '0;
      end else begin
         out_data_q  <= out_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   // Statistics are taken at acceptance; clear has priority over a same-cycle event.
   always_comb begin
      sat_flag_d  = sat_flag_q;
      sat_count_d = sat_count_q;
      if (clear_stats) begin
         sat_flag_d  = 1'b0;
         sat_count_d = '0;
      end else if (accept_w && sat_w) begin
         sat_flag_d = 1'b1;
         if (sat_count_q != 16'hFFFF) sat_count_d = sat_count_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         sat_flag_q  <= 1'b0;
         sat_count_q <= '0;
      end else begin
         sat_flag_q  <= sat_flag_d;
         sat_count_q <= sat_count_d;
      end
   end

endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: queue-based reference model checked every cycle,
// plus literal expectations for the shift/round/saturate values and handshake edges.
module tb_fir_out_requant;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] s_tdata;
   logic        s_tvalid;
   logic        s_tready;
   logic [15:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        clear_stats;
   logic        sat_flag;
   logic [15:0] sat_count;
   logic [1:0]  dbg_state;

   int n_vec  = 0;
   int n_fail = 0;

   // Reference model state: beats accepted but not yet taken, and stats.
   logic [15:0] exp_q[$];
   logic [15:0] got_q[$];
   logic        m_flag   = 1'b0;
   logic [15:0] m_count  = 16'h0;
   logic        post_rst = 1'b1;
   logic        cap_en   = 1'b0;
   logic        tog_en   = 1'b0;

   fir_out_requant #(.IN_W(32), .OUT_W(16), .SHIFT(15), .ROUND(1)) dut (
      .clk              (clk),
      .reset            (reset),
      .s_axis_rq_tdata  (s_tdata),
      .s_axis_rq_tvalid (s_tvalid),
      .s_axis_rq_tready (s_tready),
      .m_axis_rq_tdata  (m_tdata),
      .m_axis_rq_tvalid (m_tvalid),
      .m_axis_rq_tready (m_tready),
      .clear_stats      (clear_stats),
      .sat_flag         (sat_flag),
      .sat_count        (sat_count),
      .dbg_state_o      (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // floor((x + 2^14) / 2^15), clamped to the 16-bit signed range
   function automatic logic [15:0] requant(input logic [31:0] x, output bit sat);
      longint v;
      v   = longint'($signed(x));
      v   = (v + 16384) >>> 15;
      sat = 1'b0;
      if (v > 32767) begin
         v   = 32767;
         sat = 1'b1;
      end else if (v < -32768) begin
         v   = -32768;
         sat = 1'b1;
      end
      return 16'(v);
   endfunction

   // Per-cycle compare against the model, then advance the model across the next edge.
   always @(negedge clk) begin
      bit          sat;
      logic [15:0] r;
      logic        mv, mr;
      mv = (exp_q.size() != 0);
      mr = post_rst ? 1'b0 : (exp_q.size() < 2);
      chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, mv});
      chk("s_tready", {31'd0, s_tready}, {31'd0, mr});
      if (mv && m_tvalid) chk("m_tdata", {16'd0, m_tdata}, {16'd0, exp_q[0]});
      chk("sat_flag", {31'd0, sat_flag}, {31'd0, m_flag});
      chk("sat_count", {16'd0, sat_count}, {16'd0, m_count});
      if (!reset) begin
         exp_q.delete();
         m_flag   = 1'b0;
         m_count  = 16'h0;
         post_rst = 1'b1;
      end else begin
         if (mv && m_tready) begin
            r = exp_q.pop_front();
            if (cap_en) got_q.push_back(r);
         end
         sat = 1'b0;
         if (s_tvalid && mr) exp_q.push_back(requant(s_tdata, sat));
         if (clear_stats) begin
            m_flag  = 1'b0;
            m_count = 16'h0;
         end else if (s_tvalid && mr && sat) begin
            m_flag = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
         end
         post_rst = 1'b0;
      end
   end

   always @(posedge clk) begin
      #1;
      if (tog_en) m_tready = ~m_tready;
   end

   // Drivers start and end 1 time unit after a rising edge.
   task automatic send_beat(input logic [31:0] d);
      logic acc;
      int   n;
      s_tvalid = 1'b1;
      s_tdata  = d;
      n        = 0;
      acc      = 1'b0;
      while (!acc && n < 1000) begin
         @(negedge clk);
         acc = s_tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_check(input logic [31:0] d, input logic [15:0] exp);
      send_beat(d);
      s_tvalid = 1'b0;
      chk("lat_valid", {31'd0, m_tvalid}, 32'd1);
      chk("lat_data", {16'd0, m_tdata}, {16'd0, exp});
   endtask

   task automatic drain();
      int n;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      n = 0;
      while (m_tvalid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("drain", {31'd0, m_tvalid}, 32'd0);
   endtask

   initial begin
      logic [15:0] sin_tab[8];
      logic [31:0] w;
      bit          s;
      sin_tab = '{16'h0000, 16'h5A7E, 16'h7FFF, 16'h5A7E,
                  16'h0000, 16'hA582, 16'h8000, 16'hA582};
      reset = 1'b0; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b1; clear_stats = 1'b0;

      // Pin the model against hand-worked values.
      chk("pin_round_up", {16'd0, requant(32'h00004000, s)}, 32'h0001);
      chk("pin_round_dn", {16'd0, requant(32'h00003FFF, s)}, 32'h0000);
      chk("pin_neg_max",  {16'd0, requant(32'hBFFFFFFF, s)}, 32'h8000);
      chk("pin_neg_nosat", {31'd0, s}, 32'd0);
      chk("pin_pos_sat",  {16'd0, requant(32'h7FFFFFFF, s)}, 32'h7FFF);
      chk("pin_pos_sat_f", {31'd0, s}, 32'd1);

      repeat (2) @(posedge clk);
      #1;
      chk("rst_tready", {31'd0, s_tready}, 32'd0);
      chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
      chk("rst_tdata", {16'd0, m_tdata}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rel_tready", {31'd0, s_tready}, 32'd1);

      // Exact and rounding values
      send_check(32'h3FFF8000, 16'h7FFF);
      send_check(32'h00004000, 16'h0001);
      send_check(32'h00003FFF, 16'h0000);
      send_check(32'hFFFFC000, 16'h0000);
      send_check(32'hC0000000, 16'h8000);
      drain();
      chk("t1_sat_count", {16'd0, sat_count}, 32'd0);

      // Saturation: 0xBFFFFFFF lands exactly on -32768, so only two beats clamp.
      send_check(32'h40000000, 16'h7FFF);
      send_check(32'hBFFFFFFF, 16'h8000);
      send_check(32'h7FFFFFFF, 16'h7FFF);
      drain();
      chk("t2_sat_flag", {31'd0, sat_flag}, 32'd1);
      chk("t2_sat_count", {16'd0, sat_count}, 32'd2);
      clear_stats = 1'b1;
      send_beat(32'h40000000);
      clear_stats = 1'b0;
      s_tvalid = 1'b0;
      chk("t2_clr_flag", {31'd0, sat_flag}, 32'd0);
      chk("t2_clr_count", {16'd0, sat_count}, 32'd0);
      drain();

      // Backpressure mid-stream
      got_q.delete();
      cap_en = 1'b1;
      fork
         begin
            for (int k = 1; k <= 10; k++) send_beat(32'(k) << 15);
            s_tvalid = 1'b0;
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            m_tready = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            m_tready = 1'b1;
         end
      join
      drain();
      cap_en = 1'b0;
      chk("t3_count", got_q.size(), 32'd10);
      for (int k = 0; k < 10 && k < got_q.size(); k++)
         chk("t3_order", {16'd0, got_q[k]}, 32'(k + 1));

      // Sinusoid feed with toggling downstream ready
      got_q.delete();
      cap_en = 1'b1;
      tog_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         w = 32'($signed(sin_tab[i])) << 15;
         repeat (5) send_beat(w);
      end
      s_tvalid = 1'b0;
      tog_en = 1'b0;
      drain();
      cap_en = 1'b0;
      chk("t4_count", got_q.size(), 32'd40);
      for (int i = 0; i < 40 && i < got_q.size(); i++)
         chk("t4_sample", {16'd0, got_q[i]}, {16'd0, sin_tab[i / 5]});
      chk("t4_sat_count", {16'd0, sat_count}, 32'd0);

      // Reset while FULL
      m_tready = 1'b0;
      send_beat(32'h40000000);
      send_beat(32'h7FFFFFFF);
      s_tvalid = 1'b0;
      chk("t5_full_ready", {31'd0, s_tready}, 32'd0);
      chk("t5_pre_flag", {31'd0, sat_flag}, 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("t5_valid", {31'd0, m_tvalid}, 32'd0);
      chk("t5_ready", {31'd0, s_tready}, 32'd0);
      chk("t5_flag", {31'd0, sat_flag}, 32'd0);
      chk("t5_count", {16'd0, sat_count}, 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("t5_rel_ready", {31'd0, s_tready}, 32'd1);
      m_tready = 1'b1;
      send_check(32'h00010000, 16'h0002);
      drain();

      // sat_count holds at its ceiling
      for (int i = 0; i < 65540; i++) send_beat(32'h40000000);
      s_tvalid = 1'b0;
      drain();
      chk("t6_count", {16'd0, sat_count}, 32'h0000FFFF);
      chk("t6_flag", {31'd0, sat_flag}, 32'd1);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
